// File: rtl/data_mem_responder.sv
// Wait-stated data memory responder: one request at a time over valid/ready,
// fixed wait states, word access with byte enables, response held until taken.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        access;
  logic        rsp_done;

  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic [AW-1:0] acc_idx;
  logic        mem_we;

  // Power-up contents are zero; the array is never cleared by reset.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_done  = rsp_valid && rsp_ready;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With no wait states the access happens on the accept edge itself,
  // so the request fields are taken straight from the ports.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign acc_err = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:AW+2]);
  assign mem_we  = access && acc_write && !acc_err && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          access  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        err_q   <= acc_err;
        rdata_q <= (acc_write || acc_err) ? 32'h0 : mem_q[acc_idx];
      end else if (rsp_done) begin
        err_q   <= 1'b0;
        rdata_q <= 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: table of load/store transactions against a 2-wait-state
// responder, hand sequences for backpressure and reset, and a 0-wait build.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        rst_z;
  logic        req_valid_z, req_ready_z, req_write_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [3:0]  req_be_z;
  logic        rsp_valid_z, rsp_ready_z;
  logic [31:0] rsp_rdata_z;
  logic        rsp_err_z;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut_z (
    .clk(clk), .rst(rst_z),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [18];
  vec_t zvecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction on the 2-wait DUT; lat counts edges from accept to
  // the first edge at which rsp_valid is seen high.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd,
                        output logic er, output int lat);
    check("req_ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", {31'b0, rsp_valid}, 32'd0);
    check("rsp_rdata_after_hs", rsp_rdata, 32'd0);
    $display("txn w=%0d addr=0x%08h wdata=0x%08h be=%h -> rdata=0x%08h err=%0d lat=%0d",
             w, a, wd, be, rd, er, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;

    //               write  addr          wdata          be     exp_rdata      exp_err
    vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0006, 32'h5555_5555, 4'hF, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 4'h0, 32'hA5A5_A5A5, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_00FC, 32'h1234_5678, 4'h0, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 4'h0, 32'hA5A5_A5A5, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_000A, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 32'h8000_0008, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, 32'h0000_0010, 32'h0000_00AB, 4'h1, 32'h0000_0000, 1'b0};
    vecs[17] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h0000_00AB, 1'b0};

    zvecs[0] = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'h0000_0000, 1'b0};
    zvecs[1] = '{1'b1, 32'h0000_0004, 32'h600D_CAFE, 4'hF, 32'h0000_0000, 1'b0};
    zvecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0BAD_F00D, 1'b0};
    zvecs[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'h0, 32'h600D_CAFE, 1'b0};
    zvecs[4] = '{1'b0, 32'h0000_0002, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    zvecs[5] = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_be = 4'h0; rsp_ready = 1'b0;
    rst_z = 1'b1; req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = 32'h0;
    req_wdata_z = 32'h0; req_be_z = 4'h0; rsp_ready_z = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset_z_req_ready", {31'b0, req_ready_z}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_req_ready", {31'b0, req_ready}, 32'd1);

    // Table of transactions, WAIT=2 -> latency 3
    for (int i = 0; i < 18; i++) begin
      do_txn(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Backpressure: response held for 5 cycles while a competing store waits
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8; req_be = 4'h0;
    @(posedge clk); #1;
    req_write = 1'b1; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_rsp_valid", c), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bp%0d_rsp_rdata", c), rsp_rdata, 32'hDE22_BE44);
      check($sformatf("bp%0d_rsp_err", c), {31'b0, rsp_err}, 32'd0);
      check($sformatf("bp%0d_req_ready", c), {31'b0, req_ready}, 32'd0);
      $display("backpressure cycle %0d rsp_valid=%0d rdata=0x%08h req_ready=%0d",
               c, rsp_valid, rsp_rdata, req_ready);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    do_txn(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    check("bp_store_ignored", rd, 32'hDE22_BE44);

    // Reset while in WAIT: the store must not commit
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
    req_wdata = 32'h1234_5678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_wait_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("after_rst_wait_req_ready", {31'b0, req_ready}, 32'd1);
    check("after_rst_wait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("after_rst_wait_no_rsp", {31'b0, rsp_valid}, 32'd0);
    $display("reset in WAIT dropped store 0x12345678 @0x10");
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("rst_wait_prior_value", rd, 32'h0000_00AB);

    // Reset while in RESP (with rsp_ready high): committed store stays
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h14;
    req_wdata = 32'h7777_7777; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("resp_before_rst", {31'b0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b0;
    #1;
    check("rst_resp_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_resp_req_ready", {31'b0, req_ready}, 32'd1);
    $display("reset in RESP dropped response for store 0x77777777 @0x14");
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
    check("rst_resp_store_kept", rd, 32'h7777_7777);

    // WAIT=0 build: back-to-back with rsp_ready tied high
    rst_z = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("z%0d_req_ready_idle", i), {31'b0, req_ready_z}, 32'd1);
      req_valid_z = 1'b1; req_write_z = zvecs[i].write; req_addr_z = zvecs[i].addr;
      req_wdata_z = zvecs[i].wdata; req_be_z = zvecs[i].be;
      @(posedge clk); #1;
      check($sformatf("z%0d_rsp_valid", i), {31'b0, rsp_valid_z}, 32'd1);
      check($sformatf("z%0d_rdata", i), rsp_rdata_z, zvecs[i].exp_rdata);
      check($sformatf("z%0d_err", i), {31'b0, rsp_err_z}, {31'b0, zvecs[i].exp_err});
      check($sformatf("z%0d_req_ready_resp", i), {31'b0, req_ready_z}, 32'd0);
      $display("z txn w=%0d addr=0x%08h -> rdata=0x%08h err=%0d",
               zvecs[i].write, zvecs[i].addr, rsp_rdata_z, rsp_err_z);
      @(posedge clk); #1;
      check($sformatf("z%0d_rsp_valid_gap", i), {31'b0, rsp_valid_z}, 32'd0);
    end
    req_valid_z = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
